// File: rtl/cve2_instr_bus_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between the prefetch
// buffer (m0) and a secondary fetch master (m1), routing in-order responses back.
module cve2_instr_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             m0_req_i,
  input  logic [31:0]      m0_addr_i,
  output logic             m0_gnt_o,
  output logic             m0_rvalid_o,

  input  logic             m1_req_i,
  input  logic [31:0]      m1_addr_i,
  output logic             m1_gnt_o,
  output logic             m1_rvalid_o,

  output logic [31:0]      m_rdata_o,
  output logic             m_err_o,

  output logic             instr_req_o,
  input  logic             instr_gnt_i,
  output logic [31:0]      instr_addr_o,
  input  logic [31:0]      instr_rdata_i,
  input  logic             instr_err_i,
  input  logic             instr_rvalid_i,

  output logic             busy_o,
  output logic             fsm_state_o,
  output logic [CNT_W-1:0] outstanding_o
);

  // Handshake: an address-phase transfer completes in the cycle where req and
  // gnt are both high; until then req stays high and addr stays stable. Each
  // completed transfer gets exactly one single-cycle rvalid, in grant order,
  // with no back-pressure on the response side.

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic             lock_id_q, lock_id_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             id_fifo_q [MAX_OUTSTANDING];

  logic             sel;
  logic             req_int;
  logic             any_req;
  logic             full;
  logic             push;
  logic             pop;
  logic             head_id;
  logic [31:0]      addr_sel;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  assign any_req = m0_req_i | m1_req_i;
  assign full    = (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    sel       = 1'b0;
    req_int   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // Issue is judged on the registered count, so a response arriving
        // while full only reopens issue on the following cycle.
        if (!full) begin
          req_int = any_req;
          sel     = (m0_req_i && m1_req_i) ? prio_q : m1_req_i;
          if (any_req && !instr_gnt_i) begin
            state_d   = ARB_LOCKED;
            lock_id_d = sel;
          end
        end
      end
      ARB_LOCKED: begin
        sel     = lock_id_q;
        req_int = 1'b1;
        if (instr_gnt_i) begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  assign addr_sel     = sel ? m1_addr_i : m0_addr_i;
  assign instr_req_o  = rst_ni & req_int;
  assign instr_addr_o = rst_ni ? {addr_sel[31:2], 2'b00} : 32'h0;

  assign push    = instr_req_o & instr_gnt_i;
  assign pop     = instr_rvalid_i & (cnt_q != '0);
  assign head_id = id_fifo_q[rd_ptr_q];

  assign m0_gnt_o    = push & ~sel;
  assign m1_gnt_o    = push & sel;
  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop & head_id;
  assign m_rdata_o   = rst_ni ? instr_rdata_i : 32'h0;
  assign m_err_o     = rst_ni & instr_err_i;

  assign busy_o        = instr_req_o | (cnt_q != '0);
  assign fsm_state_o   = state_q;
  assign outstanding_o = cnt_q;

  assign prio_d = push ? ~sel : prio_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      lock_id_q <= 1'b0;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
    end
  end

  // Push and pop touch different slots whenever both are legal, so a
  // simultaneous push/pop needs no special-casing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        id_fifo_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
    end
  end

  spurious_rvalid_dropped: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (instr_rvalid_i && cnt_q == '0) |-> !(m0_rvalid_o || m1_rvalid_o)
  );

  no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (push && !pop) |-> (cnt_q < CNT_MAX)
  );

endmodule

// File: tb/tb_cve2_instr_bus_arbiter.sv
// Directed bench for cve2_instr_bus_arbiter: hand-computed vectors covering
// single fetch, round-robin, lock, outstanding limit, errors and reset.
module tb_cve2_instr_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        m_err_o;
  logic        instr_req_o, instr_gnt_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        instr_err_i, instr_rvalid_i;
  logic        busy_o, fsm_state_o;
  logic [1:0]  outstanding_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  cve2_instr_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .m0_req_i       (m0_req_i),
    .m0_addr_i      (m0_addr_i),
    .m0_gnt_o       (m0_gnt_o),
    .m0_rvalid_o    (m0_rvalid_o),
    .m1_req_i       (m1_req_i),
    .m1_addr_i      (m1_addr_i),
    .m1_gnt_o       (m1_gnt_o),
    .m1_rvalid_o    (m1_rvalid_o),
    .m_rdata_o      (m_rdata_o),
    .m_err_o        (m_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .instr_rvalid_i (instr_rvalid_i),
    .busy_o         (busy_o),
    .fsm_state_o    (fsm_state_o),
    .outstanding_o  (outstanding_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_i       = 1'b0;
    m1_req_i       = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_err_i    = 1'b0;
    instr_rdata_i  = 32'h0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    cyc();
    rst_ni = 1'b1;
  endtask

  logic [31:0] id;

  initial begin
    // Reset state: outputs forced low even with live inputs
    rst_ni = 1'b0;
    idle_inputs();
    m0_addr_i = 32'h0000_0F0F;
    m1_addr_i = 32'h0000_0A0A;
    m0_req_i  = 1'b1;
    instr_rdata_i = 32'h5555_AAAA;
    #1;
    check("rst_req",    instr_req_o, 0);
    check("rst_addr",   instr_addr_o, 0);
    check("rst_rdata",  m_rdata_o, 0);
    check("rst_busy",   busy_o, 0);
    check("rst_gnt",    {m1_gnt_o, m0_gnt_o}, 0);
    check("rst_state",  {fsm_state_o, outstanding_o}, 0);
    do_reset();

    // Single requester, grant delayed 2 cycles
    m0_req_i = 1'b1; m0_addr_i = 32'h0000_1003;
    for (int i = 0; i < 3; i++) begin
      instr_gnt_i = (i == 2);
      #1;
      check("single_addr", instr_addr_o, 32'h0000_1000);
      check("single_req",  instr_req_o, 1);
      check("single_gnt",  {m1_gnt_o, m0_gnt_o}, (i == 2) ? 32'd1 : 32'd0);
      cyc();
    end
    m0_req_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("single_rvalid", {m1_rvalid_o, m0_rvalid_o}, 1);
    check("single_rdata",  m_rdata_o, 32'hDEAD_BEEF);
    cyc();
    idle_inputs();
    #1;
    check("single_idle", {busy_o, outstanding_o}, 0);

    // Round-robin with back-to-back grants and responses
    do_reset();
    m0_addr_i = 32'h0000_0100;
    m1_addr_i = 32'h0000_0204;
    for (int i = 0; i < 5; i++) begin
      m0_req_i       = (i < 4);
      m1_req_i       = (i < 4);
      instr_gnt_i    = (i < 4);
      instr_rvalid_i = (i >= 1);
      instr_rdata_i  = 32'hA000_0000 + 32'(i);
      #1;
      if (i < 4) begin
        id = 32'(i % 2);
        check("rr_gnt",  {m1_gnt_o, m0_gnt_o}, (id == 1) ? 32'd2 : 32'd1);
        check("rr_addr", instr_addr_o, (id == 1) ? 32'h0000_0204 : 32'h0000_0100);
        exp_q.push_back(id);
      end
      if (i >= 1) begin
        check("rr_sb_depth", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          id = exp_q.pop_front();
          check("rr_rvalid", {m1_rvalid_o, m0_rvalid_o}, (id == 1) ? 32'd2 : 32'd1);
          check("rr_rdata",  m_rdata_o, 32'hA000_0000 + 32'(i));
        end
      end
      cyc();
    end
    idle_inputs();
    #1;
    check("rr_idle", {busy_o, outstanding_o}, 0);

    // Lock: m1 holds the port until granted even though m0 is preferred
    do_reset();
    m1_req_i = 1'b1; m1_addr_i = 32'h0000_2000; m0_addr_i = 32'h0000_3000;
    for (int c = 1; c <= 5; c++) begin
      m0_req_i    = (c >= 2);
      m1_req_i    = (c <= 4);
      instr_gnt_i = (c >= 4);
      #1;
      if (c <= 4) begin
        check("lock_addr", instr_addr_o, 32'h0000_2000);
        check("lock_gnt",  {m1_gnt_o, m0_gnt_o}, (c == 4) ? 32'd2 : 32'd0);
      end else begin
        check("lock_m0_addr", instr_addr_o, 32'h0000_3000);
        check("lock_m0_gnt",  {m1_gnt_o, m0_gnt_o}, 1);
      end
      cyc();
    end
    idle_inputs();
    instr_rvalid_i = 1'b1;
    #1;
    check("lock_resp1", {m1_rvalid_o, m0_rvalid_o}, 2);
    cyc();
    #1;
    check("lock_resp2", {m1_rvalid_o, m0_rvalid_o}, 1);
    cyc();

    // Outstanding limit: two grants, then stall until a response has popped
    do_reset();
    m0_req_i = 1'b1; m0_addr_i = 32'h0000_0300; instr_gnt_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lim_gnt", m0_gnt_o, 1);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lim_stall_req", instr_req_o, 0);
      check("lim_stall_gnt", m0_gnt_o, 0);
      check("lim_busy_cnt",  {busy_o, outstanding_o}, 32'b110);
      cyc();
    end
    instr_rvalid_i = 1'b1;
    #1;
    check("lim_rv_req",    instr_req_o, 0);
    check("lim_rv_rvalid", m0_rvalid_o, 1);
    cyc();
    instr_rvalid_i = 1'b0;
    #1;
    check("lim_resume", {instr_req_o, m0_gnt_o}, 32'b11);
    cyc();
    m0_req_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lim_drain", m0_rvalid_o, 1);
      cyc();
    end
    instr_rvalid_i = 1'b0;
    #1;
    check("lim_empty", {busy_o, outstanding_o}, 0);

    // Error response for an m1 transaction, then a spurious rvalid
    m1_req_i = 1'b1; m1_addr_i = 32'h0000_0400; instr_gnt_i = 1'b1;
    #1;
    check("err_gnt", {m1_gnt_o, m0_gnt_o}, 2);
    cyc();
    m1_req_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_err_i = 1'b1; instr_rdata_i = 32'h0000_BAD0;
    #1;
    check("err_rvalid", {m1_rvalid_o, m0_rvalid_o}, 2);
    check("err_flag",   m_err_o, 1);
    cyc();
    instr_err_i = 1'b0;
    #1;
    check("spur_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
    cyc();
    instr_rvalid_i = 1'b0;
    #1;
    check("spur_cnt", {busy_o, outstanding_o}, 0);

    // Reset while LOCKED with one outstanding
    m0_req_i = 1'b1; m0_addr_i = 32'h0000_0500; instr_gnt_i = 1'b1;
    #1;
    check("mid_gnt0", m0_gnt_o, 1);
    cyc();
    m0_req_i = 1'b0; m1_req_i = 1'b1; m1_addr_i = 32'h0000_0600; instr_gnt_i = 1'b0;
    #1;
    check("mid_addr1", instr_addr_o, 32'h0000_0600);
    cyc();
    m0_req_i = 1'b1;
    #1;
    check("mid_locked", {fsm_state_o, outstanding_o}, 32'b101);
    rst_ni = 1'b0; instr_rdata_i = 32'h0000_1234; instr_err_i = 1'b1;
    #1;
    check("mid_rst_req",  {instr_req_o, busy_o}, 0);
    check("mid_rst_addr", instr_addr_o, 0);
    check("mid_rst_data", {m_err_o, m_rdata_o[30:0]}, 0);
    check("mid_rst_hs",   {m1_gnt_o, m0_gnt_o, m1_rvalid_o, m0_rvalid_o}, 0);
    check("mid_rst_st",   {fsm_state_o, outstanding_o}, 0);
    cyc();
    rst_ni = 1'b1; instr_gnt_i = 1'b1; instr_rvalid_i = 1'b1;
    instr_err_i = 1'b0; instr_rdata_i = 32'h0;
    #1;
    check("post_rst_addr",   instr_addr_o, 32'h0000_0500);
    check("post_rst_gnt",    {m1_gnt_o, m0_gnt_o}, 1);
    check("post_rst_spur",   {m1_rvalid_o, m0_rvalid_o}, 0);
    cyc();
    idle_inputs();
    #1;
    check("post_rst_cnt", outstanding_o, 1);
    instr_rvalid_i = 1'b1;
    #1;
    check("post_rst_resp", {m1_rvalid_o, m0_rvalid_o}, 1);
    cyc();
    idle_inputs();

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cve2_instr_bus_arbiter.md
# cve2_instr_bus_arbiter

Two-requester arbiter sharing the single core instruction-memory port (req/gnt address phase, in-order rvalid response phase) between the prefetch buffer (requester 0) and a secondary instruction-side master such as a debug or trace fetch unit (requester 1). It sits between those requesters and the instruction memory or cache. It performs round-robin arbitration, holds the chosen requester until the downstream grant, and tracks up to MAX_OUTSTANDING granted transactions so each response is routed back to the requester that issued it.

## Interface
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered transactions (≥1).
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- m0_req_i / m1_req_i  input  1  requester address-phase request.
- m0_addr_i / m1_addr_i  input  32  requester word address; must stay stable while req is high and gnt is low.
- m0_gnt_o / m1_gnt_o  output  1  grant to requester.
- m0_rvalid_o / m1_rvalid_o  output  1  response valid to requester.
- m_rdata_o  output  32  response data, broadcast to both requesters.
- m_err_o  output  1  response error, broadcast to both requesters.
- instr_req_o  output  1  downstream request.
- instr_gnt_i  input  1  downstream grant.
- instr_addr_o  output  32  downstream address; bits [1:0] forced to 0.
- instr_rdata_i  input  32  downstream read data.
- instr_err_i  input  1  downstream bus error.
- instr_rvalid_i  input  1  downstream response valid.
- busy_o  output  1  a request is pending or outstanding.

## Operation
- State:
  - lock_q / lock_id_q: an issued request is waiting for grant, and which requester issued it.
  - prio_q: the preferred requester.
  - cnt_q: outstanding count, 0..MAX_OUTSTANDING.
  - id_fifo: requester IDs, MAX_OUTSTANDING deep, with read/write pointers that wrap modulo MAX_OUTSTANDING.
- Arbitration (two-state FSM, IDLE / LOCKED):
  - IDLE with cnt_q < MAX_OUTSTANDING: sel is the sole requester, or prio_q if both request.
    - instr_req_o = m0_req_i | m1_req_i.
    - No grant that cycle: go to LOCKED with lock_id_q = sel.
  - IDLE with cnt_q == MAX_OUTSTANDING: instr_req_o = 0, no grants. A same-cycle rvalid does not open issue; issue resumes the next cycle.
  - LOCKED: sel = lock_id_q and instr_req_o = 1, regardless of the other requester and of cnt_q. On instr_gnt_i, return to IDLE.
- Routing:
  - instr_addr_o = {addr of sel[31:2], 2'b00}.
  - mX_gnt_o = instr_req_o & instr_gnt_i & (sel == X).
- Grant event (instr_req_o & instr_gnt_i):
  - Push sel into id_fifo.
  - prio_q ← ~sel.
- Response (instr_rvalid_i):
  - Pop the id_fifo head.
  - Assert m<head>_rvalid_o.
  - m_rdata_o / m_err_o pass through combinationally.
- Count update:
  - Push and pop in the same cycle: cnt_q unchanged and the FIFO slot is reused correctly.
  - Push only: +1. Pop only: −1.
- Spurious rvalid (cnt_q == 0): dropped.
  - Neither mX_rvalid_o asserts.
  - cnt_q stays 0.
  - Covered by a simulation assertion.
- busy_o = instr_req_o | (cnt_q != 0).
- Reset mid-operation clears the lock, the count and the FIFO. Responses still in flight after reset release are treated as spurious.

## Timing
- Reset values:
  - All outputs 0.
  - prio_q = 0 (requester 0 preferred).
  - FSM in IDLE, cnt_q = 0.
- Zero-cycle combinational paths, with no added latency:
  - mX_req_i → instr_req_o / instr_addr_o.
  - instr_gnt_i → mX_gnt_o.
  - instr_rvalid_i → mX_rvalid_o.
- The fairness pointer and the lock take effect the cycle after the event that updates them.
- Back-to-back grants every cycle are supported while cnt_q < MAX_OUTSTANDING, or while a response pops in the same cycle.
- A response may arrive the cycle after its grant at the earliest. Same-cycle grant and rvalid for different transactions is legal.

## Test plan
- Single requester:
  - Stimulus: m0 requests addr 0x0000_1003; gnt is delayed 2 cycles; rvalid follows 1 cycle after gnt with rdata 0xDEAD_BEEF.
  - Response: instr_addr_o = 0x0000_1000 held 3 cycles; one m0_gnt_o pulse; m0_rvalid_o with 0xDEAD_BEEF; m1 signals stay 0.
- Round-robin:
  - Stimulus: m0 and m1 both request continuously; gnt = 1 every cycle; rvalid = 1 every cycle starting 1 cycle after the first grant.
  - Response: grant order m0, m1, m0, m1; rvalid routed in the same order.
- Lock:
  - Stimulus: m1 alone requests with gnt held low; m0 raises req one cycle later; gnt is asserted on cycle 4.
  - Response: instr_addr_o stays m1's address until cycle 4; m1 is granted; m0 is granted on a following cycle.
- Outstanding limit:
  - Stimulus: MAX_OUTSTANDING = 2; 3 requests; no rvalid until cycle 5.
  - Response: instr_req_o = 0 after 2 grants; issue resumes the cycle after the first rvalid.
- Error and spurious response:
  - Stimulus: instr_err_i = 1 with rvalid for an m1 transaction.
  - Response: m_err_o = 1 together with m1_rvalid_o.
  - Stimulus: rvalid with cnt_q = 0.
  - Response: no mX_rvalid_o; cnt_q stays 0.
- Reset mid-operation:
  - Stimulus: assert rst_ni = 0 while in LOCKED with 1 outstanding.
  - Response: all outputs 0 immediately; after release, m0 has priority.
